lsu_mem_initiator: RTL

Load/store initiator between the RISC-V execute stage and the data-memory bus. It accepts one load or store request per transaction, decoded by RV32I funct3. It drives word-addressed bus requests with byte strobes and lane-replicated write data. Load data is returned aligned and sign- or zero-extended. Misaligned, illegal and timed-out accesses are reported as errors without corrupting memory.

---
 rtl/lsu_mem_initiator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the RV32I execute stage and a word-addressed data bus.
// Decodes funct3 into byte strobes and lane-replicated write data, and aligns/extends load data.
module lsu_mem_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // Request handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_ready is high only in IDLE. The response is a single-cycle resp_valid pulse, no backpressure.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;
  localparam logic [7:0] WAIT_LAST     = 8'(TIMEOUT - 1);

  state_t                  state;
  logic [7:0]              wait_cnt;
  logic                    cap_we;
  logic [2:0]              cap_funct3;
  logic [1:0]              cap_addr_lo;

  logic                    req_illegal;
  logic                    req_misaligned;
  logic [3:0]              req_strb;
  logic [DATA_WIDTH-1:0]   req_bus_wdata;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;
  logic [DATA_WIDTH-1:0]   load_data;

  assign dbg_state = state;

  // Classification of the incoming request; illegal outranks misaligned at the use site.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (req_funct3)
      3'b000:         req_illegal = 1'b0;
      3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101: req_illegal = req_we;
      default:        req_illegal = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01)
      req_misaligned = req_addr[0];
    else if (req_funct3[1:0] == 2'b10)
      req_misaligned = (req_addr[1:0] != 2'b00);
  end

  // Strobes and lane-replicated data; loads drive neither.
  always_comb begin
    req_strb      = 4'b0000;
    req_bus_wdata = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          req_strb      = 4'b0001 << req_addr[1:0];
          req_bus_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          req_strb      = req_addr[1] ? 4'b1100 : 4'b0011;
          req_bus_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          req_strb      = 4'b1111;
          req_bus_wdata = req_wdata;
        end
      endcase
    end
  end

  // Load alignment and extension from the captured funct3 and low address bits.
  always_comb begin
    load_byte = mem_rdata[{cap_addr_lo, 3'b000} +: 8];
    load_half = cap_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = '0;
    if (!cap_we) begin
      case (cap_funct3)
        3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
        3'b100:  load_data = {24'd0, load_byte};
        3'b001:  load_data = {{16{load_half[15]}}, load_half};
        3'b101:  load_data = {16'd0, load_half};
        default: load_data = mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      cap_we      <= 1'b0;
      cap_funct3  <= 3'b000;
      cap_addr_lo <= 2'b00;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= ERR_OK;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wstrb   <= 4'b0000;
      mem_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_we      <= req_we;
            cap_funct3  <= req_funct3;
            cap_addr_lo <= req_addr[1:0];
            req_ready   <= 1'b0;
            if (req_illegal || req_misaligned) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= req_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
            end else begin
              state     <= S_ISSUE;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wstrb <= req_strb;
              mem_wdata <= req_bus_wdata;
            end
          end
        end
        S_ISSUE: begin
          // No timeout here: the bus may stall the grant indefinitely.
          if (mem_gnt) begin
            state    <= S_WAIT;
            mem_req  <= 1'b0;
            wait_cnt <= 8'd0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            resp_err   <= ERR_OK;
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
